// File: rtl/throw_ctrl.sv
// Turn and throw sequencer: alternates local/remote turns, converts a held
// throw button into a saturating 5-bit power level, exchanges throws with the
// board link and hands each throw to the trajectory renderer.
module throw_ctrl #(
  parameter int unsigned TICK_DIV  = 1_000_000,  // clk40MHz cycles per power step
  parameter int unsigned MAX_POWER = 31          // charge saturation value, <= 31
) (
  input  logic       clk40MHz,
  input  logic       rst,
  input  logic       game_active,
  input  logic       my_player,
  input  logic       btn_throw,
  input  logic [4:0] in_power,
  input  logic       in_throw_flag,
  input  logic       flight_done,
  output logic [4:0] out_power,
  output logic       out_throw_flag,
  output logic [4:0] throw_power,
  output logic       throw_owner,
  output logic       flight_start,
  output logic       my_turn,
  output logic       charging,
  output logic [4:0] charge_level,
  output logic [7:0] turn
);

  localparam int unsigned   CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [4:0]    POWER_MAX = 5'(MAX_POWER);
  localparam logic          PLAYER_1  = 1'b0;

  typedef enum logic [2:0] {
    WAIT_START,
    MY_AIM,
    CHARGE,
    FLIGHT,
    THEIR_AIM
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             armed;   // button seen released since this turn began

  // Sequencer: state, turn bookkeeping and every registered output.
  always_ff @(posedge clk40MHz) begin
    // NOTE: non-blocking assignments throughout; the default-low strobes below
    // are overridden later in the same block only on the cycle they fire.
    out_throw_flag <= 1'b0;
    flight_start   <= 1'b0;

    if (rst || !game_active) begin
      // Reset and abort share one path: anything in progress is discarded,
      // including a strobe that would otherwise fire this cycle.
      state        <= WAIT_START;
      tick_cnt     <= '0;
      armed        <= 1'b0;
      out_power    <= '0;
      throw_power  <= '0;
      throw_owner  <= 1'b0;
      my_turn      <= 1'b0;
      charging     <= 1'b0;
      charge_level <= '0;
      turn         <= '0;
    end else begin
      unique case (state)
        WAIT_START: begin
          turn <= '0;
          if (my_player == PLAYER_1) begin
            state   <= MY_AIM;
            my_turn <= 1'b1;
          end else begin
            state   <= THEIR_AIM;
          end
        end

        MY_AIM: begin
          // A button already held when the turn starts must be released first.
          if (!btn_throw) begin
            armed <= 1'b1;
          end else if (armed) begin
            state        <= CHARGE;
            charging     <= 1'b1;
            charge_level <= 5'd1;
            tick_cnt     <= '0;
          end
        end

        CHARGE: begin
          if (!btn_throw) begin
            // Level is at least 1 here, so a zero power never reaches the link.
            out_power      <= charge_level;
            out_throw_flag <= 1'b1;
            throw_power    <= charge_level;
            throw_owner    <= my_player;
            flight_start   <= 1'b1;
            armed          <= 1'b0;
            my_turn        <= 1'b0;
            charging       <= 1'b0;
            charge_level   <= '0;
            state          <= FLIGHT;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (charge_level < POWER_MAX) begin
              charge_level <= charge_level + 5'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        THEIR_AIM: begin
          // Power 0 with the strobe is a link handshake, not a throw.
          if (in_throw_flag && (in_power != 5'd0)) begin
            throw_power  <= in_power;
            throw_owner  <= ~my_player;
            flight_start <= 1'b1;
            state        <= FLIGHT;
          end
        end

        FLIGHT: begin
          // Buttons and remote strobes are ignored until the projectile lands.
          if (flight_done) begin
            turn <= turn + 8'd1;
            if (throw_owner == my_player) begin
              state <= THEIR_AIM;
            end else begin
              state   <= MY_AIM;
              my_turn <= 1'b1;
            end
          end
        end

        default: begin
          state <= WAIT_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_throw_ctrl.sv
// Directed bench for throw_ctrl with a short power tick (TICK_DIV = 4).
module tb_throw_ctrl;

  logic       clk40MHz = 1'b0;
  logic       rst;
  logic       game_active;
  logic       my_player;
  logic       btn_throw;
  logic [4:0] in_power;
  logic       in_throw_flag;
  logic       flight_done;
  logic [4:0] out_power;
  logic       out_throw_flag;
  logic [4:0] throw_power;
  logic       throw_owner;
  logic       flight_start;
  logic       my_turn;
  logic       charging;
  logic [4:0] charge_level;
  logic [7:0] turn;

  int n_cmp  = 0;
  int n_fail = 0;

  throw_ctrl #(.TICK_DIV(4), .MAX_POWER(31)) dut (
    .clk40MHz      (clk40MHz),
    .rst           (rst),
    .game_active   (game_active),
    .my_player     (my_player),
    .btn_throw     (btn_throw),
    .in_power      (in_power),
    .in_throw_flag (in_throw_flag),
    .flight_done   (flight_done),
    .out_power     (out_power),
    .out_throw_flag(out_throw_flag),
    .throw_power   (throw_power),
    .throw_owner   (throw_owner),
    .flight_start  (flight_start),
    .my_turn       (my_turn),
    .charging      (charging),
    .charge_level  (charge_level),
    .turn          (turn)
  );

  always #5 clk40MHz = ~clk40MHz;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; outputs are sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk40MHz);
      #1;
    end
  endtask

  // One local throw at power 1 from MY_AIM, landed back into THEIR_AIM.
  task automatic local_round();
    btn_throw = 1'b0; step();    // arm
    btn_throw = 1'b1; step();    // enter CHARGE, level 1
    btn_throw = 1'b0; step();    // release -> throw
    flight_done = 1'b1; step();
    flight_done = 1'b0;
  endtask

  // One remote throw from THEIR_AIM, landed back into MY_AIM.
  task automatic remote_round();
    in_power = 5'd5; in_throw_flag = 1'b1; step();
    in_throw_flag = 1'b0;
    flight_done = 1'b1; step();
    flight_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; game_active = 1'b0; my_player = 1'b0; btn_throw = 1'b0;
    in_power = '0; in_throw_flag = 1'b0; flight_done = 1'b0;
    step(2);
    check("rst_my_turn", my_turn, 0);
    check("rst_turn", turn, 0);
    check("rst_out_power", out_power, 0);
    check("rst_flight_start", flight_start, 0);
    check("rst_charge_level", charge_level, 0);

    // Start as PLAYER_1 -> MY_AIM.
    rst = 1'b0; game_active = 1'b1;
    step();
    check("start_my_turn", my_turn, 1);
    check("start_charging", charging, 0);
    check("start_turn", turn, 0);
    check("start_flag", out_throw_flag, 0);

    // Local throw: arm, press for 10 edges, release.
    step();
    btn_throw = 1'b1; step();
    check("charge_enter", charging, 1);
    check("charge_level1", charge_level, 1);
    step(9);
    check("charge_level_10cyc", charge_level, 3);
    btn_throw = 1'b0; step();
    check("rel_out_flag", out_throw_flag, 1);
    check("rel_flight_start", flight_start, 1);
    check("rel_out_power", out_power, 3);
    check("rel_throw_power", throw_power, 3);
    check("rel_owner", throw_owner, 0);
    check("rel_my_turn", my_turn, 0);
    check("rel_level_zero", charge_level, 0);
    step();
    check("pulse_flag_off", out_throw_flag, 0);
    check("pulse_start_off", flight_start, 0);
    check("out_power_hold", out_power, 3);

    // Remote strobe during FLIGHT is ignored.
    in_power = 5'd9; in_throw_flag = 1'b1; step();
    check("flight_strobe_ign", flight_start, 0);
    check("flight_power_hold", throw_power, 3);
    // Land together with a remote strobe: landing wins, strobe dropped.
    flight_done = 1'b1; step();
    flight_done = 1'b0; in_throw_flag = 1'b0;
    check("land_turn1", turn, 1);
    check("land_no_start", flight_start, 0);
    check("land_their_aim", my_turn, 0);
    step();
    check("dropped_strobe", flight_start, 0);
    check("dropped_power", throw_power, 3);

    // Remote throws: power 0 ignored, power 17 accepted.
    in_power = 5'd0; in_throw_flag = 1'b1; step();
    check("zero_power_ign", flight_start, 0);
    in_power = 5'd17; step();
    in_throw_flag = 1'b0;
    check("remote_start", flight_start, 1);
    check("remote_power", throw_power, 17);
    check("remote_owner", throw_owner, 1);
    btn_throw = 1'b1;   // held across the landing
    step();
    check("remote_pulse_off", flight_start, 0);
    flight_done = 1'b1; step();
    flight_done = 1'b0;
    check("remote_land_turn", turn, 2);
    check("remote_land_myturn", my_turn, 1);
    step(3);
    check("held_btn_no_charge", charging, 0);
    flight_done = 1'b1; step();
    flight_done = 1'b0;
    check("done_in_aim_ign", turn, 2);
    check("done_in_aim_state", my_turn, 1);

    // Saturation: hold well past 31 steps.
    btn_throw = 1'b0; step();
    btn_throw = 1'b1; step();
    check("sat_enter", charge_level, 1);
    step(200);
    check("sat_level", charge_level, 31);
    btn_throw = 1'b0; step();
    check("sat_out_power", out_power, 31);
    check("sat_flag", out_throw_flag, 1);
    step();

    // Abort mid-FLIGHT.
    game_active = 1'b0; step();
    check("abort_fl_turn", turn, 0);
    check("abort_fl_tpower", throw_power, 0);
    check("abort_fl_opower", out_power, 0);
    check("abort_fl_myturn", my_turn, 0);
    flight_done = 1'b1; step();
    flight_done = 1'b0;
    check("wait_done_ign", turn, 0);

    // Restart, then abort mid-CHARGE coinciding with release.
    game_active = 1'b1; step();
    check("restart_myturn", my_turn, 1);
    check("restart_turn", turn, 0);
    step();
    btn_throw = 1'b1; step(4);
    check("abort_ch_charging", charging, 1);
    btn_throw = 1'b0; game_active = 1'b0; step();
    check("abort_ch_flag", out_throw_flag, 0);
    check("abort_ch_start", flight_start, 0);
    check("abort_ch_charging0", charging, 0);
    check("abort_ch_opower", out_power, 0);
    check("abort_ch_level", charge_level, 0);

    // Start as PLAYER_2 -> THEIR_AIM; button ignored there.
    my_player = 1'b1; game_active = 1'b1; step();
    check("p2_their_aim", my_turn, 0);
    btn_throw = 1'b1; step(2);
    check("p2_btn_ign", charging, 0);
    btn_throw = 1'b0;

    // Turn wrap: 127 full rounds (254 landings), then two more landings.
    for (int i = 0; i < 127; i++) begin
      remote_round();
      local_round();
    end
    check("wrap_254", turn, 254);
    remote_round();
    check("wrap_255", turn, 255);
    check("wrap_remote_owner", throw_owner, 0);
    local_round();
    check("wrap_0", turn, 0);
    check("wrap_local_owner", throw_owner, 1);
    check("wrap_state", my_turn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
